// File: rtl/sparse_pkg.sv
// sparse_pkg: shared defaults, index-width helper and packet types for the N:M sparse PE
package sparse_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_M          = 4;
    localparam int DEF_N          = 2;
    localparam int DEF_GROUPS     = 4;
    localparam int DEF_ACC_WIDTH  = 24;

    // Width of an in-group position index; at least one bit even for M = 1.
    function automatic int idx_w(input int m);
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

    // Compressed N:M weight packet at the default geometry, group-major.
    typedef struct packed {
        logic [DEF_GROUPS-1:0][DEF_N-1:0][DEF_DATA_WIDTH-1:0] val;
        logic [DEF_GROUPS-1:0][DEF_N-1:0][idx_w(DEF_M)-1:0]   idx;
    } nm_pkt_t;

    // Dense activation vector at the default geometry.
    typedef logic [DEF_GROUPS*DEF_M-1:0][DEF_DATA_WIDTH-1:0] act_vec_t;

endpackage

// File: rtl/sparse_group_mult.sv
// sparse_group_mult: one N:M group, N activation index muxes feeding N signed multipliers
module sparse_group_mult
    import sparse_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int M          = DEF_M,
    parameter int N          = DEF_N,
    parameter int IDX_W      = idx_w(DEF_M),
    parameter int PROD_W     = 2 * DATA_WIDTH
) (
    input  logic [M*DATA_WIDTH-1:0] act,
    input  logic [N*DATA_WIDTH-1:0] w_val,
    input  logic [N*IDX_W-1:0]      w_idx,
    output logic [N*PROD_W-1:0]     prod
);

    logic signed [DATA_WIDTH-1:0] a_sel [N];

    // Pick the activation each weight points at; out-of-range indices fall back to position 0.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            a_sel[k] = act[DATA_WIDTH-1:0];
            for (int j = 1; j < M; j++)
                if (w_idx[k*IDX_W +: IDX_W] == IDX_W'(j)) a_sel[k] = act[j*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_mul
        logic signed [PROD_W-1:0] p;
        assign p = a_sel[k] * $signed(w_val[k*DATA_WIDTH +: DATA_WIDTH]);
        assign prod[k*PROD_W +: PROD_W] = p;
    end

endmodule

// File: rtl/sparse_nm_mac_pe.sv
// sparse_nm_mac_pe: pipelined N:M sparse multiply, reduce and multi-packet accumulate PE
module sparse_nm_mac_pe
    import sparse_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int M          = DEF_M,
    parameter int N          = DEF_N,
    parameter int GROUPS     = DEF_GROUPS,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int SATURATE   = 1,
    parameter int IDX_W      = idx_w(M)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             in_last,
    input  logic [GROUPS*N*DATA_WIDTH-1:0]   w_val,
    input  logic [GROUPS*N*IDX_W-1:0]        w_idx,
    input  logic [GROUPS*M*DATA_WIDTH-1:0]   act_vec,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [ACC_WIDTH-1:0]             out_data,
    output logic                             out_sat
);

    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int LANES  = GROUPS * N;
    localparam int SUM_W  = PROD_W + $clog2(LANES);
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic                     stall;
    logic [LANES*PROD_W-1:0]  prod;
    logic [LANES*PROD_W-1:0]  s1_prod;
    logic                     s1_valid, s1_last;
    logic signed [SUM_W-1:0]  sum;
    logic signed [SUM_W-1:0]  s2_sum;
    logic                     s2_valid, s2_last;
    logic signed [ACC_WIDTH-1:0] acc;
    logic                     flag;
    logic signed [ACC_WIDTH:0] nxt;
    logic                     ovf;
    logic signed [ACC_WIDTH-1:0] res;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    for (genvar g = 0; g < GROUPS; g++) begin : g_grp
        sparse_group_mult #(
            .DATA_WIDTH(DATA_WIDTH),
            .M         (M),
            .N         (N),
            .IDX_W     (IDX_W),
            .PROD_W    (PROD_W)
        ) u_grp (
            .act  (act_vec[g*M*DATA_WIDTH +: M*DATA_WIDTH]),
            .w_val(w_val[g*N*DATA_WIDTH +: N*DATA_WIDTH]),
            .w_idx(w_idx[g*N*IDX_W +: N*IDX_W]),
            .prod (prod[g*N*PROD_W +: N*PROD_W])
        );
    end

    // S1: register the products with their valid/last tags whenever the pipe advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_prod  <= '0;
        end else if (!stall) begin
            s1_valid <= in_valid;
            s1_last  <= in_last;
            s1_prod  <= prod;
        end
    end

    // Signed reduction of all lane products, each sign-extended to the tree width.
    always_comb begin
        sum = '0;
        for (int i = 0; i < LANES; i++) sum = sum + SUM_W'($signed(s1_prod[i*PROD_W +: PROD_W]));
    end

    // S2: register the packet sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_sum   <= '0;
        end else if (!stall) begin
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s2_sum   <= sum;
        end
    end

    assign nxt = (ACC_WIDTH+1)'(acc) + (ACC_WIDTH+1)'(s2_sum);
    assign ovf = nxt[ACC_WIDTH] ^ nxt[ACC_WIDTH-1];
    assign res = (ovf && SATURATE != 0) ? (nxt[ACC_WIDTH] ? ACC_MIN : ACC_MAX) : nxt[ACC_WIDTH-1:0];

    // S3: accumulate, and on a last beat publish the result and restart the dot product clean.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            flag      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (!stall) begin
            out_valid <= s2_valid & s2_last;
            if (s2_valid && s2_last) begin
                out_data <= res;
                out_sat  <= flag | ovf;
                acc      <= '0;
                flag     <= 1'b0;
            end else if (s2_valid) begin
                acc  <= res;
                flag <= flag | ovf;
            end
        end
    end

endmodule
